// File: rtl/busreq_responder.sv
// Bus-request responder: decodes the core's 4-bit BUSREQ codes and answers them
// with operand nibbles from a small program memory and register-file reads and writes.
module busreq_responder #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 16,
  parameter int PDEPTH = 16,
  localparam int PW    = (PDEPTH > 1) ? $clog2(PDEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        busreq,
  input  logic [DATA_W-1:0] wdata,
  output logic [3:0]        opnd,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err,
  input  logic              prog_we,
  input  logic [PW-1:0]     prog_addr,
  input  logic [3:0]        prog_data,
  output logic [PW-1:0]     pc
);

  typedef enum logic [3:0] {
    REQ_IDLE  = 4'd0,
    REQ_READ  = 4'd1,
    REQ_WRITE = 4'd2,
    REQ_NEXT  = 4'd3,
    REQ_PCRST = 4'd4
  } req_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVE,
    S_HOLD
  } state_e;

  state_e            state;
  state_e            state_next;
  req_e              code_q;
  logic [3:0]        cur_reg;
  logic              capture;
  logic              serve;
  logic              illegal;
  logic [DATA_W-1:0] regs [NREGS];
  logic [3:0]        pmem [PDEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Illegal codes are only noticed while idle; a held code is served once and then parked in S_HOLD.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    serve      = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_IDLE: begin
        if (busreq > 4'd4) begin
          illegal = 1'b1;
        end else if (busreq != 4'd0) begin
          capture    = 1'b1;
          state_next = S_SERVE;
        end
      end
      S_SERVE: begin
        serve      = 1'b1;
        state_next = S_HOLD;
      end
      S_HOLD: begin
        if (busreq != code_q) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_q <= REQ_IDLE;
      err    <= 1'b0;
      ack    <= 1'b0;
    end else begin
      if (capture) code_q <= req_e'(busreq);
      if (illegal) err <= 1'b1;
      ack <= serve;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opnd    <= '0;
      rdata   <= '0;
      pc      <= '0;
      cur_reg <= '0;
    end else if (serve) begin
      case (code_q)
        REQ_NEXT: begin
          opnd    <= pmem[pc];
          cur_reg <= pmem[pc];
          pc      <= pc + PW'(1);
        end
        REQ_READ:  rdata <= regs[cur_reg];
        REQ_WRITE: rdata <= wdata;
        REQ_PCRST: pc    <= '0;
        default: ;
      endcase
    end
  end

  // wdata is taken in the serve cycle, so the core may present its ALU result after issuing the code.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (serve && code_q == REQ_WRITE) begin
      regs[cur_reg] <= wdata;
    end
  end

  // Nonblocking update gives read-before-write against a same-cycle NEXT_OPERAND.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PDEPTH; i++) pmem[i] <= '0;
    end else if (prog_we) begin
      pmem[prog_addr] <= prog_data;
    end
  end

endmodule

// File: tb/tb_busreq_responder.sv
// Randomized transaction-level check of busreq_responder against a request-by-request
// model of program memory, register file, operand pointer and sticky error flag.
module tb_busreq_responder;

  localparam int DATA_W = 8;
  localparam int NREGS  = 16;
  localparam int PDEPTH = 16;
  localparam int PW     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        busreq = 4'd0;
  logic [DATA_W-1:0] wdata = '0;
  logic              prog_we = 1'b0;
  logic [PW-1:0]     prog_addr = '0;
  logic [3:0]        prog_data = '0;
  logic [3:0]        opnd;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;
  logic              err;
  logic [PW-1:0]     pc;

  int vectors = 0;
  int miscompares = 0;
  int ackSeen = 0;

  logic [3:0]        mPmem [PDEPTH];
  logic [DATA_W-1:0] mRegs [NREGS];
  int                mPc;
  logic [3:0]        mCur;
  logic [3:0]        mOpnd;
  logic [DATA_W-1:0] mRdata;
  logic              mErr;

  busreq_responder #(.DATA_W(DATA_W), .NREGS(NREGS), .PDEPTH(PDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .busreq(busreq), .wdata(wdata),
    .opnd(opnd), .rdata(rdata), .ack(ack), .busy(busy), .err(err),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .pc(pc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ack) ackSeen++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < PDEPTH; i++) mPmem[i] = '0;
    for (int i = 0; i < NREGS; i++) mRegs[i] = '0;
    mPc = 0; mCur = '0; mOpnd = '0; mRdata = '0; mErr = 1'b0;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_opnd"}, opnd, mOpnd);
    checkOutput({tag, "_rdata"}, rdata, mRdata);
    checkOutput({tag, "_pc"}, pc, mPc);
    checkOutput({tag, "_err"}, err, mErr);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  task automatic loadProg(input logic [PW-1:0] addr, input logic [3:0] data);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    @(negedge clk);
    prog_we = 1'b0;
    mPmem[addr] = data;
  endtask

  // One request held for 'hold' cycles, then released to 0000 and allowed to settle.
  task automatic applyStimulus(input string tag, input logic [3:0] code, input logic [DATA_W-1:0] wd, input int hold);
    int startAcks;
    int waited;
    int expAcks;
    startAcks = ackSeen;
    @(negedge clk);
    busreq = code; wdata = wd;
    repeat (hold) @(negedge clk);
    busreq = 4'd0;
    repeat (3) @(negedge clk);
    waited = 0;
    while (busy && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    expAcks = 1;
    case (code)
      4'd0: expAcks = 0;
      4'd1: mRdata = mRegs[mCur];
      4'd2: begin mRegs[mCur] = wd; mRdata = wd; end
      4'd3: begin mOpnd = mPmem[mPc]; mCur = mOpnd; mPc = (mPc + 1) % PDEPTH; end
      4'd4: mPc = 0;
      default: begin mErr = 1'b1; expAcks = 0; end
    endcase
    checkOutput({tag, "_acks"}, ackSeen - startAcks, expAcks);
    checkState(tag);
  endtask

  initial begin
    int startAcks;
    logic [3:0] oldNib;
    logic [3:0] firstNib;
    int r;
    modelReset();

    repeat (3) @(negedge clk);
    checkOutput("rst_opnd", opnd, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_pc", pc, 0);
    rst_n = 1'b1;

    loadProg(4'd0, 4'd1);
    loadProg(4'd1, 4'd3);

    @(negedge clk); busreq = 4'd3;
    @(negedge clk);
    checkOutput("first_ack_early", ack, 0);
    checkOutput("first_busy", busy, 1);
    @(negedge clk);
    checkOutput("first_ack", ack, 1);
    checkOutput("first_opnd", opnd, 1);
    checkOutput("first_pc", pc, 1);
    busreq = 4'd0;
    @(negedge clk);
    checkOutput("first_ack_once", ack, 0);
    repeat (2) @(negedge clk);
    mOpnd = 4'd1; mCur = 4'd1; mPc = 1;
    checkState("first");

    applyStimulus("wr6", 4'd2, 8'd6, 1);
    applyStimulus("rd6", 4'd1, 8'd0, 1);
    checkOutput("reg1_value", rdata, 8'd6);

    applyStimulus("held", 4'd3, 8'd0, 10);

    applyStimulus("pcrst0", 4'd4, 8'd0, 1);
    for (int i = 0; i < PDEPTH; i++) loadProg(PW'(i), 4'($urandom));
    firstNib = mPmem[0];
    for (int i = 0; i < 17; i++) applyStimulus("wrap", 4'd3, 8'd0, 1);
    checkOutput("wrap_opnd17", opnd, firstNib);
    applyStimulus("pcrst1", 4'd4, 8'd0, 2);

    // Program write to the address being fetched in the same serve cycle.
    oldNib = mPmem[mPc];
    @(negedge clk); busreq = 4'd3;
    @(negedge clk);
    prog_we = 1'b1; prog_addr = PW'(mPc); prog_data = ~oldNib;
    @(negedge clk);
    prog_we = 1'b0; busreq = 4'd0;
    repeat (3) @(negedge clk);
    mPmem[mPc] = ~oldNib;
    mOpnd = oldNib; mCur = oldNib; mPc = (mPc + 1) % PDEPTH;
    checkState("rbw");

    startAcks = ackSeen;
    @(negedge clk); busreq = 4'b1010;
    @(negedge clk);
    checkOutput("illegal_err", err, 1);
    checkOutput("illegal_busy", busy, 0);
    busreq = 4'd0;
    repeat (3) @(negedge clk);
    checkOutput("illegal_noack", ackSeen - startAcks, 0);
    mErr = 1'b1;
    applyStimulus("after_illegal", 4'd1, 8'd0, 1);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      applyStimulus("rnd_next", 4'd3, 8'd0, $urandom_range(1, 4));
      else if (r < 50) applyStimulus("rnd_read", 4'd1, 8'd0, $urandom_range(1, 4));
      else if (r < 70) applyStimulus("rnd_write", 4'd2, 8'($urandom), $urandom_range(1, 4));
      else if (r < 78) applyStimulus("rnd_pcrst", 4'd4, 8'd0, $urandom_range(1, 4));
      else if (r < 90) loadProg(4'($urandom), 4'($urandom));
      else if (r < 93) applyStimulus("rnd_illegal", 4'($urandom_range(5, 15)), 8'd0, $urandom_range(1, 3));
      else             applyStimulus("rnd_idle", 4'd0, 8'd0, 1);
    end

    // Reset lands on the serve cycle of a REG_WRITE.
    applyStimulus("pre_rst", 4'd3, 8'd0, 1);
    startAcks = ackSeen;
    @(negedge clk); busreq = 4'd2; wdata = 8'd9;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_opnd", opnd, 0);
    checkOutput("midrst_rdata", rdata, 0);
    checkOutput("midrst_ack", ack, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_err", err, 0);
    checkOutput("midrst_pc", pc, 0);
    rst_n = 1'b1; busreq = 4'd0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_noack", ackSeen - startAcks, 0);
    modelReset();
    applyStimulus("post_rst_read", 4'd1, 8'd0, 1);
    applyStimulus("post_rst_next", 4'd3, 8'd0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/busreq_responder.md
# busreq_responder

Bus-request responder on the far side of the core's BUSREQ interface. It decodes 4-bit request codes from `tt_um_warriorjacq9`'s `uo_out[3:0]` and answers them. It supplies the next operand nibble from a small program memory (to `ui_in[7:4]`). It returns or updates a register-file entry (via `uio_in`, with write data taken from `uio_out`). It sits beside the core at the top level in place of a bench-driven stub.

## Interface
Parameters:
- `DATA_W`, 8: register width, which is also the `rdata`/`wdata` width.
- `NREGS`, 16: register count, fixed by the 4-bit operand.
- `PDEPTH`, 16: program memory depth in nibbles, which must be a power of 2 (≤16).

Ports:
- `clk`, in, 1: the single clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `busreq`, in, 4: request code from the core.
- `wdata`, in, DATA_W: write data from the core (ALU result).
- `opnd`, out, 4: operand nibble to the core.
- `rdata`, out, DATA_W: register value to the core.
- `ack`, out, 1: one-cycle pulse when a request completes.
- `busy`, out, 1: high while the FSM is not in `S_IDLE`.
- `err`, out, 1: sticky flag for an illegal request code.
- `prog_we`, in, 1: program-memory write enable.
- `prog_addr`, in, log2(PDEPTH): program-memory write address.
- `prog_data`, in, 4: program-memory write data.
- `pc`, out, log2(PDEPTH): current operand pointer (debug).

## Operation
- Request codes:
  - `0000` IDLE.
  - `0001` REG_READ.
  - `0010` REG_WRITE.
  - `0011` NEXT_OPERAND.
  - `0100` PC_RESET.
  - `0101`–`1111` are illegal.
- Internal state: a `cur_reg` 4-bit register that holds the last operand delivered. REG_READ and REG_WRITE address register `cur_reg`.
- FSM states: `S_IDLE`, `S_SERVE`, `S_HOLD`.
  - `S_IDLE`:
    - A legal non-IDLE `busreq` captures the code into `code_q` and moves to `S_SERVE`.
    - An illegal code sets `err` and stays in `S_IDLE` with no ack.
    - IDLE stays in `S_IDLE`.
  - `S_SERVE` performs the captured action at the clock edge, asserts `ack`, and moves to `S_HOLD`. The actions are:
    - NEXT_OPERAND: `opnd <= pmem[pc]`, `cur_reg <= pmem[pc]`, `pc <= pc+1` (wraps modulo PDEPTH).
    - REG_READ: `rdata <= regs[cur_reg]`.
    - REG_WRITE: `regs[cur_reg] <= wdata`, and `rdata <= wdata` (write-through).
    - PC_RESET: `pc <= 0`. `opnd` and `rdata` are unchanged.
  - `S_HOLD`: stays while `busreq == code_q`. Any change, including a direct change to another code, returns to `S_IDLE`. A held code is therefore serviced exactly once.
- `wdata` is sampled in the `S_SERVE` cycle, not at capture.
- Program memory:
  - `prog_we` writes `pmem[prog_addr]` at any time, independent of the FSM.
  - A NEXT_OPERAND read of the same address in the same cycle returns the old data (read-before-write).
- `opnd` and `rdata` are registered and hold their value until the next action that updates them.

## Timing
- Code first seen at edge k (FSM in `S_IDLE`):
  - Edge k: capture, enter `S_SERVE`.
  - Edge k+1: data updated, `ack` high for exactly the cycle k+1..k+2.
  - Latency is 2 edges from code to valid data.
- Back-to-back: a code change seen in `S_HOLD` at edge m returns to `S_IDLE`. It is recaptured at m+1 and acked at m+2. Minimum request spacing is 3 cycles.
- `busy` is high from edge k to the edge that leaves `S_HOLD`.
- `busreq` changing during `S_SERVE` has no effect. The captured code completes, and `S_HOLD` then sees the mismatch.
- Reset (`rst_n == 0` at any edge, including mid-`S_SERVE`):
  - Next state is `S_IDLE`.
  - `opnd`, `rdata`, `ack`, `busy`, `err`, `pc`, `cur_reg`, `code_q` all become 0.
  - All `regs` and `pmem` entries become 0.
  - A `prog_we` or REG_WRITE in the reset cycle is dropped.
- `err` clears only on reset.

## Test plan
- Program memory load and first operand: reset, load `pmem[0]=1`, `pmem[1]=3`, then `busreq=0011`. Required: `opnd=1` and a single 1-cycle `ack` 2 edges later, with `pc=1` and `busy` low after return to `0000`.
- Register write then read: after operand 1, set `busreq=0010` with `wdata=6`, then `busreq=0001`. Required: `regs[1]=6` and `rdata=6`, with two acks spaced ≥3 cycles.
- Held request: `busreq=0011` held for 10 cycles. Required: exactly one ack and `pc` incremented once.
- Wrap-around: 17 NEXT_OPERAND requests separated by `0000`. Required: `pc` runs 0..15 then back to 0, and the 17th `opnd` equals `pmem[0]`. Then PC_RESET sets `pc=0`.
- Illegal code: `busreq=1010`. Required: `err=1` the next cycle, no ack, and `err` still 1 after `0000` and a subsequent legal request.
- Reset mid-operation: `rst_n=0` during the `S_SERVE` cycle of a REG_WRITE with `wdata=9`. Required: the next edge shows all outputs 0, `regs[cur_reg]` stays 0, and `ack` never pulses.
